// File: rtl/pran_mailbox_responder.sv
// pran_mailbox_responder
//
// Memory-mapped mailbox that sits beside data memory in pran_riscv_cpu.
// The host loads argument words while the CPU is held in reset, then starts
// the run. The CPU signals completion by storing 1 to the DONE word. The
// result word is latched at that moment, and the host reads it back.
//
// Optional feature: define MBOX_WATCHDOG_EN to abort a run that reaches
// WDOG_LIMIT RUN cycles without a DONE write. The run then ends in TIMEOUT.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   host_we/idx/wdata host word write, accepted only in IDLE
//   host_rdata        combinational read of word[host_idx]
//   host_start        pulse, IDLE -> RUN
//   host_ack          pulse, DONE/TIMEOUT -> IDLE
//   MemWrite/DataAdr/WriteData  CPU store port
//   mbox_hit          DataAdr is word-aligned and inside the window
//   mbox_rdata        combinational word[DataAdr[4:2]] for CPU loads
//   cpu_reset         registered reset to the CPU core
//   busy/done/timeout one-hot view of RUN/DONE/TIMEOUT
//   result            word[RESULT_IDX], latched on DONE entry
//   run_cycles        saturating count of RUN cycles
//
// Handshake: host_start and host_ack are single-cycle pulses. Each pulse is
// sampled at exactly one rising edge and takes effect only in the state that
// accepts it; a pulse that arrives in any other state is dropped, not queued.
// The busy, done and timeout outputs report the state the pulse produced.

module pran_mailbox_responder #(
  parameter logic [31:0] MBOX_BASE  = 32'h02000000,
  parameter int unsigned RESULT_IDX = 1,
  parameter int unsigned DONE_IDX   = 2,
  parameter logic [31:0] WDOG_LIMIT = 32'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_we,
  input  logic [2:0]  host_idx,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  input  logic        host_start,
  input  logic        host_ack,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        mbox_hit,
  output logic [31:0] mbox_rdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] result,
  output logic [31:0] run_cycles
);

  localparam logic [2:0] RES_I  = 3'(RESULT_IDX);
  localparam logic [2:0] DONE_I = 3'(DONE_IDX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic [31:0] result_q, result_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic [31:0] word_q [8];

  // Word write request. There is one write port because only one side
  // (host in IDLE, CPU in RUN) is allowed to write in any given state.
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic        clr_done;

  logic [2:0]  cpu_idx;
  logic        done_store;
  logic [31:0] run_inc;

  assign cpu_idx    = DataAdr[4:2];
  assign mbox_hit   = (DataAdr[31:5] == MBOX_BASE[31:5]) && (DataAdr[1:0] == 2'b00);
  assign mbox_rdata = word_q[cpu_idx];
  assign host_rdata = word_q[host_idx];

  assign done_store = MemWrite && mbox_hit && (cpu_idx == DONE_I) && (WriteData == 32'd1);
  assign run_inc    = (run_cycles_q == 32'hFFFF_FFFF) ? run_cycles_q : run_cycles_q + 32'd1;

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    cpu_reset_d  = cpu_reset_q;
    result_d     = result_q;
    run_cycles_d = run_cycles_q;
    wr_en        = 1'b0;
    wr_idx       = host_idx;
    wr_data      = host_wdata;
    clr_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_reset_d = 1'b1;
        // A write and a start in the same cycle both take effect.
        if (host_we) wr_en = 1'b1;
        if (host_start) begin
          run_cycles_d = 32'd0;
          cpu_reset_d  = 1'b0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        run_cycles_d = run_inc;
        if (MemWrite && mbox_hit) begin
          wr_en   = 1'b1;
          wr_idx  = cpu_idx;
          wr_data = WriteData;
        end
        if (done_store) begin
          // The result word may be the DONE word itself, and that word is
          // being written on this edge. Take the store data in that case.
          result_d    = (RES_I == DONE_I) ? WriteData : word_q[RES_I];
          cpu_reset_d = 1'b1;
          state_d     = S_DONE;
        end
`ifdef MBOX_WATCHDOG_EN
        // A DONE store on the limit cycle wins. The branch above takes it.
        else if (run_inc >= WDOG_LIMIT) begin
          result_d    = 32'hDEAD_BEEF;
          cpu_reset_d = 1'b1;
          state_d     = S_TIMEOUT;
        end
`endif
      end
      S_DONE, S_TIMEOUT: begin
        cpu_reset_d = 1'b1;
        if (host_ack) begin
          clr_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        cpu_reset_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cpu_reset_q  <= 1'b1;
      result_q     <= 32'd0;
      run_cycles_q <= 32'd0;
      for (int i = 0; i < 8; i++) word_q[i] <= 32'd0;
    end else begin
      state_q      <= state_d;
      cpu_reset_q  <= cpu_reset_d;
      result_q     <= result_d;
      run_cycles_q <= run_cycles_d;
      if (wr_en)    word_q[wr_idx] <= wr_data;
      if (clr_done) word_q[DONE_I] <= 32'd0;
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign result     = result_q;
  assign run_cycles = run_cycles_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

`ifdef MBOX_WATCHDOG_EN
  assign timeout = (state_q == S_TIMEOUT);
`else
  assign timeout = 1'b0;
  logic unused_wdog;
  assign unused_wdog = ^WDOG_LIMIT;
`endif

endmodule

// File: tb/tb_pran_mailbox_responder.sv
// Directed bench for pran_mailbox_responder in its default build, with the
// watchdog disabled. Inputs change 1 ns after a rising edge. Outputs are
// checked at that same point, so they are read away from the edge.

module tb_pran_mailbox_responder;

  logic        clk;
  logic        reset;
  logic        host_we;
  logic [2:0]  host_idx;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_start;
  logic        host_ack;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        mbox_hit;
  logic [31:0] mbox_rdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] result;
  logic [31:0] run_cycles;

  int total = 0;
  int bad   = 0;

  pran_mailbox_responder dut (
    .clk        (clk),
    .reset      (reset),
    .host_we    (host_we),
    .host_idx   (host_idx),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_start (host_start),
    .host_ack   (host_ack),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .mbox_hit   (mbox_hit),
    .mbox_rdata (mbox_rdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .result     (result),
    .run_cycles (run_cycles)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic idle_inputs();
    host_we = 0; host_idx = 0; host_wdata = 0; host_start = 0; host_ack = 0;
    MemWrite = 0; DataAdr = 0; WriteData = 0;
  endtask

  task automatic host_write(input logic [2:0] idx, input logic [31:0] data);
    host_we = 1; host_idx = idx; host_wdata = data;
    tick();
    host_we = 0;
  endtask

  task automatic cpu_store(input logic [31:0] adr, input logic [31:0] data);
    MemWrite = 1; DataAdr = adr; WriteData = data;
    tick();
    MemWrite = 0;
  endtask

  task automatic pulse_start();
    host_start = 1; tick(); host_start = 0;
  endtask

  task automatic pulse_ack();
    host_ack = 1; tick(); host_ack = 0;
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1;
    tick(); tick();
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (run_cycles !== 32'd0) begin bad++; $display("FAIL reset_run_cycles got=%0d exp=0", run_cycles); end
    for (int i = 0; i < 8; i++) begin
      host_idx = 3'(i); #1;
      total++; if (host_rdata !== 32'd0) begin bad++; $display("FAIL reset_word%0d got=%h exp=0", i, host_rdata); end
    end
    reset = 0;
    tick();
  endtask

  task automatic test_sum_program();
    host_write(3'd0, 32'd20);
    host_write(3'd1, 32'd0);
    host_write(3'd2, 32'd0);
    host_idx = 3'd0; #1;
    total++; if (host_rdata !== 32'd20) begin bad++; $display("FAIL sum_word0_loaded got=%0d exp=20", host_rdata); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL sum_idle_cpu_reset got=%b exp=1", cpu_reset); end
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sum_busy got=%b exp=1", busy); end
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL sum_run_cpu_reset got=%b exp=0", cpu_reset); end
    total++; if (run_cycles !== 32'd0) begin bad++; $display("FAIL sum_run_start got=%0d exp=0", run_cycles); end
    repeat (10) tick();
    total++; if (run_cycles !== 32'd10) begin bad++; $display("FAIL sum_run_count got=%0d exp=10", run_cycles); end
    DataAdr = 32'h0200_0004; #1;
    total++; if (mbox_hit !== 1'b1) begin bad++; $display("FAIL sum_hit got=%b exp=1", mbox_hit); end
    cpu_store(32'h0200_0004, 32'd210);
    total++; if (mbox_rdata !== 32'd210) begin bad++; $display("FAIL sum_mbox_rdata got=%0d exp=210", mbox_rdata); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL sum_not_done_yet got=%b exp=0", done); end
    cpu_store(32'h0200_0008, 32'd1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sum_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sum_busy_cleared got=%b exp=0", busy); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL sum_done_cpu_reset got=%b exp=1", cpu_reset); end
    total++; if (result !== 32'd210) begin bad++; $display("FAIL sum_result got=%0d exp=210", result); end
    total++; if (run_cycles !== 32'd12) begin bad++; $display("FAIL sum_run_final got=%0d exp=12", run_cycles); end
    host_write(3'd0, 32'd999);  // ignored in DONE
    tick();
    total++; if (run_cycles !== 32'd12) begin bad++; $display("FAIL sum_run_held got=%0d exp=12", run_cycles); end
    host_idx = 3'd0; #1;
    total++; if (host_rdata !== 32'd20) begin bad++; $display("FAIL sum_done_we_ignored got=%0d exp=20", host_rdata); end
    pulse_ack();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL sum_ack_idle got=done%b busy%b exp=done0 busy0", done, busy); end
    total++; if (result !== 32'd210) begin bad++; $display("FAIL sum_result_kept got=%0d exp=210", result); end
    host_idx = 3'd2; #1;
    total++; if (host_rdata !== 32'd0) begin bad++; $display("FAIL sum_word2_cleared got=%0d exp=0", host_rdata); end
    host_idx = 3'd0; #1;
    total++; if (host_rdata !== 32'd20) begin bad++; $display("FAIL sum_word0_kept got=%0d exp=20", host_rdata); end
    host_idx = 3'd1; #1;
    total++; if (host_rdata !== 32'd210) begin bad++; $display("FAIL sum_word1_kept got=%0d exp=210", host_rdata); end
  endtask

  task automatic test_spurious();
    cpu_store(32'h0200_0004, 32'd99);  // IDLE: ignored
    host_idx = 3'd1; #1;
    total++; if (host_rdata !== 32'd210) begin bad++; $display("FAIL spur_idle_store got=%0d exp=210", host_rdata); end
    pulse_ack();                        // IDLE: ignored
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL spur_idle_ack got=busy%b done%b exp=busy0 done0", busy, done); end
    pulse_start();
    cpu_store(32'h0200_0008, 32'd2);
    host_idx = 3'd2; #1;
    total++; if (host_rdata !== 32'd2) begin bad++; $display("FAIL spur_done_word2 got=%0d exp=2", host_rdata); end
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL spur_still_run got=busy%b done%b exp=busy1 done0", busy, done); end
    DataAdr = 32'h0200_0006; #1;
    total++; if (mbox_hit !== 1'b0) begin bad++; $display("FAIL spur_misaligned_hit got=%b exp=0", mbox_hit); end
    cpu_store(32'h0200_0006, 32'd77);
    host_idx = 3'd1; #1;
    total++; if (host_rdata !== 32'd210) begin bad++; $display("FAIL spur_misaligned_word got=%0d exp=210", host_rdata); end
    DataAdr = 32'h0200_0020; #1;
    total++; if (mbox_hit !== 1'b0) begin bad++; $display("FAIL spur_outside_hit got=%b exp=0", mbox_hit); end
    cpu_store(32'h0200_0020, 32'd66);
    host_idx = 3'd0; #1;
    total++; if (host_rdata !== 32'd20) begin bad++; $display("FAIL spur_outside_word got=%0d exp=20", host_rdata); end
    host_write(3'd3, 32'd55);           // RUN: ignored
    host_idx = 3'd3; #1;
    total++; if (host_rdata !== 32'd0) begin bad++; $display("FAIL spur_run_host_we got=%0d exp=0", host_rdata); end
    pulse_ack();                        // RUN: ignored
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL spur_run_ack got=%b exp=1", busy); end
    cpu_store(32'h0200_0008, 32'd1);
    total++; if (done !== 1'b1 || result !== 32'd210) begin bad++; $display("FAIL spur_finish got=done%b result%0d exp=done1 result210", done, result); end
    pulse_ack();
  endtask

  task automatic test_same_cycle_start();
    host_we = 1; host_idx = 3'd0; host_wdata = 32'd5; host_start = 1;
    tick();
    host_we = 0; host_start = 0;
    host_idx = 3'd0; #1;
    total++; if (host_rdata !== 32'd5) begin bad++; $display("FAIL same_word0 got=%0d exp=5", host_rdata); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL same_busy got=%b exp=1", busy); end
  endtask

  task automatic test_reset_mid_run();
    repeat (50) tick();
    total++; if (run_cycles !== 32'd50) begin bad++; $display("FAIL mid_run_count got=%0d exp=50", run_cycles); end
    reset = 1;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_state got=busy%b done%b exp=busy0 done0", busy, done); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL mid_cpu_reset got=%b exp=1", cpu_reset); end
    total++; if (run_cycles !== 32'd0) begin bad++; $display("FAIL mid_run_cycles got=%0d exp=0", run_cycles); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL mid_result got=%h exp=0", result); end
    for (int i = 0; i < 8; i++) begin
      host_idx = 3'(i); #1;
      total++; if (host_rdata !== 32'd0) begin bad++; $display("FAIL mid_word%0d got=%h exp=0", i, host_rdata); end
    end
    reset = 0;
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_sum_program();
    test_spurious();
    test_same_cycle_start();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
